// File: rtl/e_route_compute.sv
// rtl/e_route_compute.sv - XY route computation and packet transfer control for the east input port
// Optional feature macro: E_ROUTE_COMPUTE_STATS_EN adds the pkt_count_o completed-packet counter.
module e_route_compute #(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2,
  parameter int LEN_WIDTH   = 4,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ib_empty_i,
  input  logic [DATA_WIDTH-1:0] ib_data_i,
  input  logic                  out_ready_i,
  output logic                  ib_read_o,
  output logic [2:0]            nhr_address_o,
  output logic                  nhr_write_o,
  output logic                  pt_almost_done_o,
  output logic                  busy_o
`ifdef E_ROUTE_COMPUTE_STATS_EN
  ,
  output logic [15:0]           pkt_count_o
`endif
);

  localparam int HDR_W = 2*COORD_WIDTH + LEN_WIDTH;

  localparam logic [2:0] PORT_LOCAL = 3'b000;
  localparam logic [2:0] PORT_NORTH = 3'b001;
  localparam logic [2:0] PORT_SOUTH = 3'b010;
  localparam logic [2:0] PORT_NONE  = 3'b011;
  localparam logic [2:0] PORT_EAST  = 3'b100;
  localparam logic [2:0] PORT_WEST  = 3'b101;

  typedef enum logic [1:0] {IDLE, ROUTE, XFER} state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] hdr_x, hdr_y;
  logic [LEN_WIDTH-1:0]   hdr_len;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic [2:0]             addr_q;
  logic [2:0]             route_d;
  logic                   capture;
  logic                   pop;
  logic                   last_pop;
  logic                   unused_data;

  assign hdr_x   = ib_data_i[COORD_WIDTH-1:0];
  assign hdr_y   = ib_data_i[2*COORD_WIDTH-1:COORD_WIDTH];
  assign hdr_len = ib_data_i[HDR_W-1:2*COORD_WIDTH];

  // Payload bits above the header fields are carried by the crossbar, not used here.
  assign unused_data = ^ib_data_i[DATA_WIDTH-1:HDR_W];

  // Header is sampled but left in the buffer; it is popped as the first XFER flit.
  assign capture  = (state_q == IDLE) && !ib_empty_i;
  assign pop      = (state_q == XFER) && !ib_empty_i && out_ready_i;
  assign last_pop = pop && (cnt_q == LEN_WIDTH'(1));

  assign nhr_address_o = addr_q;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  always_comb begin
    route_d = PORT_LOCAL;
    if (hdr_x > COORD_WIDTH'(LOCAL_X))      route_d = PORT_EAST;
    else if (hdr_x < COORD_WIDTH'(LOCAL_X)) route_d = PORT_WEST;
    else if (hdr_y > COORD_WIDTH'(LOCAL_Y)) route_d = PORT_NORTH;
    else if (hdr_y < COORD_WIDTH'(LOCAL_Y)) route_d = PORT_SOUTH;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)  state_d = ROUTE;
      ROUTE:                 state_d = XFER;
      XFER:    if (last_pop) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and counter.
  always_comb begin
    ib_read_o        = pop;
    nhr_write_o      = (state_q == ROUTE);
    pt_almost_done_o = (state_q == XFER) && (cnt_q == LEN_WIDTH'(1));
    busy_o           = (state_q != IDLE);
  end

  // Route/length capture and remaining-flit counter; a zero length still moves the header.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= PORT_NONE;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (capture) begin
        addr_q <= route_d;
        len_q  <= hdr_len;
      end else if (last_pop) begin
        addr_q <= PORT_NONE;
      end
      if (state_q == ROUTE)
        cnt_q <= (len_q == '0) ? LEN_WIDTH'(1) : len_q;
      else if (pop && (cnt_q > LEN_WIDTH'(1)))
        cnt_q <= cnt_q - LEN_WIDTH'(1);
    end
  end

`ifdef E_ROUTE_COMPUTE_STATS_EN
  // Completed-packet counter, wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pkt_count_o <= '0;
    else if (last_pop) pkt_count_o <= pkt_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_e_route_compute.sv
// tb/tb_e_route_compute.sv - self-checking bench for e_route_compute (LOCAL_X=1, LOCAL_Y=1)
module tb_e_route_compute;

  localparam int LX = 1;
  localparam int LY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ib_empty_i;
  logic [31:0] ib_data_i;
  logic        out_ready_i;
  logic        ib_read_o;
  logic [2:0]  nhr_address_o;
  logic        nhr_write_o;
  logic        pt_almost_done_o;
  logic        busy_o;
`ifdef E_ROUTE_COMPUTE_STATS_EN
  logic [15:0] pkt_count_o;
`endif

  e_route_compute #(
    .DATA_WIDTH(32), .COORD_WIDTH(2), .LEN_WIDTH(4), .LOCAL_X(LX), .LOCAL_Y(LY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ib_empty_i(ib_empty_i),
    .ib_data_i(ib_data_i),
    .out_ready_i(out_ready_i),
    .ib_read_o(ib_read_o),
    .nhr_address_o(nhr_address_o),
    .nhr_write_o(nhr_write_o),
    .pt_almost_done_o(pt_almost_done_o),
    .busy_o(busy_o)
`ifdef E_ROUTE_COMPUTE_STATS_EN
    ,
    .pkt_count_o(pkt_count_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo[$];
  logic        s_read, s_write, s_almost, s_busy;
  logic [2:0]  s_addr;

  typedef struct {
    int         x;
    int         y;
    int         len;
    logic [2:0] addr;
    int         pops;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Spec routing rule, straight from the coordinate comparisons.
  function automatic logic [2:0] exp_route(input int x, input int y);
    if (x > LX) return 3'b100;
    if (x < LX) return 3'b101;
    if (y > LY) return 3'b001;
    if (y < LY) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [31:0] hdr(input int x, input int y, input int len);
    logic [31:0] h;
    h      = $urandom;
    h[1:0] = x[1:0];
    h[3:2] = y[1:0];
    h[7:4] = len[3:0];
    return h;
  endfunction

  // One clock: drive buffer-model inputs, sample outputs mid-cycle, pop model on a read.
  task automatic step(input bit st_empty, input bit rdy);
    ib_empty_i  = (fifo.size() == 0) || st_empty;
    if (fifo.size() != 0) ib_data_i = fifo[0];
    else                  ib_data_i = '0;
    out_ready_i = rdy;
    @(negedge clk);
    s_read   = ib_read_o;
    s_write  = nhr_write_o;
    s_addr   = nhr_address_o;
    s_almost = pt_almost_done_o;
    s_busy   = busy_o;
    if (ib_empty_i || !out_ready_i) chk("read_gated", int'(s_read), 0);
    @(posedge clk);
    if (s_read && fifo.size() != 0) void'(fifo.pop_front());
    #1;
  endtask

  // Transaction-level check of the packet at the buffer head.
  task automatic observe_packet(input logic [2:0] ea, input int ep, input bit rnd, input string nm);
    int         writes = 0;
    int         pops = 0;
    int         bad = 0;
    logic [2:0] wa = 3'b011;
    for (int c = 0; c < 400 && pops < ep; c++) begin
      bit se;
      bit rd;
      se = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(se, rd);
      if (s_write) begin
        writes++;
        wa = s_addr;
        if (s_read || !s_busy || pops != 0) bad++;
      end
      if (s_read) begin
        pops++;
        if (writes != 1) bad++;
        if (s_almost != (pops == ep)) bad++;
      end
    end
    chk({nm, "_writes"}, writes, 1);
    chk({nm, "_addr"}, int'(wa), int'(ea));
    chk({nm, "_pops"}, pops, ep);
    chk({nm, "_order"}, bad, 0);
    step(1'b1, 1'b1);
    chk({nm, "_idle_busy"}, int'(s_busy), 0);
    chk({nm, "_idle_addr"}, int'(s_addr), 3);
  endtask

  task automatic run_packet(input int x, input int y, input int len, input bit rnd, input string nm);
    int n;
    n = (len == 0) ? 1 : len;
    fifo.push_back(hdr(x, y, len));
    for (int i = 1; i < n; i++) fifo.push_back($urandom);
    observe_packet(exp_route(x, y), n, rnd, nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{x: 3, y: 0, len: 3,  addr: 3'b100, pops: 3};
    vt[1] = '{x: 1, y: 2, len: 1,  addr: 3'b001, pops: 1};
    vt[2] = '{x: 1, y: 0, len: 1,  addr: 3'b010, pops: 1};
    vt[3] = '{x: 1, y: 1, len: 1,  addr: 3'b000, pops: 1};
    vt[4] = '{x: 0, y: 1, len: 1,  addr: 3'b101, pops: 1};
    vt[5] = '{x: 2, y: 2, len: 0,  addr: 3'b100, pops: 1};
    vt[6] = '{x: 1, y: 3, len: 15, addr: 3'b001, pops: 15};
    vt[7] = '{x: 0, y: 0, len: 2,  addr: 3'b101, pops: 2};

    reset       = 1'b1;
    ib_empty_i  = 1'b1;
    ib_data_i   = '0;
    out_ready_i = 1'b0;

    // Reset values before any clock edge.
    #3;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_addr", int'(nhr_address_o), 3);
    chk("rst_write", int'(nhr_write_o), 0);
    chk("rst_read", int'(ib_read_o), 0);
    chk("rst_almost", int'(pt_almost_done_o), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Scenario 1, cycle by cycle.
    fifo.push_back(hdr(3, 0, 3));
    fifo.push_back($urandom);
    fifo.push_back($urandom);
    step(1'b0, 1'b1);
    chk("s1_idle_write", int'(s_write), 0);
    chk("s1_idle_read", int'(s_read), 0);
    chk("s1_idle_addr", int'(s_addr), 3);
    step(1'b0, 1'b1);
    chk("s1_route_write", int'(s_write), 1);
    chk("s1_route_addr", int'(s_addr), 4);
    chk("s1_route_read", int'(s_read), 0);
    chk("s1_route_busy", int'(s_busy), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("s1_xfer_read", int'(s_read), 1);
      chk("s1_xfer_almost", int'(s_almost), (i == 2) ? 1 : 0);
      chk("s1_xfer_addr", int'(s_addr), 4);
      chk("s1_xfer_write", int'(s_write), 0);
    end
    step(1'b1, 1'b1);
    chk("s1_done_busy", int'(s_busy), 0);
    chk("s1_done_addr", int'(s_addr), 3);

    // Table vectors (scenarios 2 and 4 plus boundaries).
    for (int i = 0; i < 8; i++) begin
      fifo.push_back(hdr(vt[i].x, vt[i].y, vt[i].len));
      for (int k = 1; k < vt[i].pops; k++) fifo.push_back($urandom);
      observe_packet(vt[i].addr, vt[i].pops, 1'b0, $sformatf("vec%0d", i));
    end

    // Scenario 4 detail: len=0 shows almost-done in the first XFER cycle.
    fifo.push_back(hdr(1, 1, 0));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s4_first_xfer_almost", int'(s_almost), 1);
    chk("s4_first_xfer_read", int'(s_read), 0);
    step(1'b0, 1'b1);
    chk("s4_pop", int'(s_read), 1);
    step(1'b1, 1'b1);
    chk("s4_idle", int'(s_busy), 0);

    // Scenario 3: stall for 2 cycles after the 2nd pop.
    fifo.push_back(hdr(3, 3, 4));
    for (int k = 1; k < 4; k++) fifo.push_back($urandom);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("s3_two_popped", fifo.size(), 2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      chk("s3_stall_read", int'(s_read), 0);
      chk("s3_stall_almost", int'(s_almost), 0);
      chk("s3_stall_busy", int'(s_busy), 1);
    end
    step(1'b0, 1'b1);
    chk("s3_pop3_almost", int'(s_almost), 0);
    chk("s3_pop3_read", int'(s_read), 1);
    step(1'b0, 1'b1);
    chk("s3_pop4_almost", int'(s_almost), 1);
    chk("s3_pop4_read", int'(s_read), 1);
    chk("s3_all_popped", fifo.size(), 0);
    step(1'b1, 1'b1);
    chk("s3_idle", int'(s_busy), 0);

    // Back-to-back headers: IDLE cycle sits between the last pop and the next ROUTE.
    fifo.push_back(hdr(3, 1, 1));
    fifo.push_back(hdr(1, 1, 1));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("b2b_pop", int'(s_read), 1);
    step(1'b0, 1'b1);
    chk("b2b_gap_busy", int'(s_busy), 0);
    chk("b2b_gap_write", int'(s_write), 0);
    chk("b2b_gap_addr", int'(s_addr), 3);
    step(1'b0, 1'b1);
    chk("b2b_route_write", int'(s_write), 1);
    chk("b2b_route_addr", int'(s_addr), 0);
    step(1'b0, 1'b1);
    chk("b2b_pop2", int'(s_read), 1);
    step(1'b1, 1'b1);

    // Scenario 5: asynchronous reset after 2 pops of a len=5 packet.
    fifo.push_back(hdr(3, 0, 5));
    for (int k = 1; k < 5; k++) fifo.push_back(hdr(1, 1, 1));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("s5_mid_busy", int'(busy_o), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("s5_rst_busy", int'(busy_o), 0);
    chk("s5_rst_read", int'(ib_read_o), 0);
    chk("s5_rst_addr", int'(nhr_address_o), 3);
    chk("s5_rst_write", int'(nhr_write_o), 0);
    chk("s5_rst_almost", int'(pt_almost_done_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("s5_left_in_buf", fifo.size(), 3);
    observe_packet(3'b000, 1, 1'b0, "s5_new_hdr");
    fifo.delete();

    // Randomized packets with random stalls against the routing rule.
    for (int i = 0; i < 30; i++) begin
      run_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15), 1'b1,
                 $sformatf("rnd%0d", i));
    end

`ifdef E_ROUTE_COMPUTE_STATS_EN
    // Scenario 6: packet counter and wrap.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("s6_rst_count", int'(pkt_count_o), 0);
    for (int i = 0; i < 3; i++) run_packet(2, 1, i + 1, 1'b0, "s6_pkt");
    chk("s6_count3", int'(pkt_count_o), 3);
    force dut.pkt_count_o = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_count_o;
    chk("s6_preload", int'(pkt_count_o), 16'hFFFF);
    run_packet(0, 0, 2, 1'b0, "s6_wrap_pkt");
    chk("s6_wrap", int'(pkt_count_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_route_compute.md
E_ROUTE_COMPUTE -- requirements
Module: e_route_compute

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, flit width; COORD_WIDTH, default 2, width of each mesh coordinate; LEN_WIDTH, default 4, packet-length field width; LOCAL_X, default 0, this router's X coordinate; LOCAL_Y, default 0, this router's Y coordinate.
REQ-002 Ports SHALL be:
  clk  in  1  single clock, rising edge;
  reset  in  1  asynchronous, active-high;
  ib_empty_i  in  1  east input buffer empty;
  ib_data_i  in  DATA_WIDTH  flit at input buffer head;
  out_ready_i  in  1  downstream crossbar accepts a flit this cycle;
  ib_read_o  out  1  pop input buffer head;
  nhr_address_o  out  3  computed next-hop port;
  nhr_write_o  out  1  one-cycle write strobe to next-hop register;
  pt_almost_done_o  out  1  last flit of packet pending;
  busy_o  out  1  packet in progress.
REQ-003 The header flit layout SHALL be: dest_x = ib_data_i[COORD_WIDTH-1:0]; dest_y = [2*COORD_WIDTH-1:COORD_WIDTH]; len = [2*COORD_WIDTH+LEN_WIDTH-1:2*COORD_WIDTH], which is the flit count including the header.
REQ-004 The port encoding SHALL be: 000 local, 001 north, 010 south, 100 east, 101 west, 011 none/idle.

Function
REQ-005 The FSM SHALL have three states: IDLE, ROUTE, XFER.
REQ-006 In IDLE with ib_empty_i=0, the FSM SHALL capture dest_x, dest_y and len from ib_data_i and go to ROUTE next cycle; it SHALL NOT pop the header.
REQ-007 ROUTE SHALL last exactly one cycle and assert nhr_write_o=1.
REQ-008 In ROUTE, nhr_address_o SHALL be the registered XY route: dest_x>LOCAL_X east; dest_x<LOCAL_X west; on X equality, dest_y>LOCAL_Y north, dest_y<LOCAL_Y south, otherwise local.
REQ-009 In ROUTE, the remaining-flit counter SHALL be loaded with len, and len=0 SHALL be treated as 1.
REQ-010 In XFER, ib_read_o SHALL equal (!ib_empty_i & out_ready_i), combinationally, and each asserted cycle SHALL decrement the counter by 1.
REQ-011 pt_almost_done_o SHALL be 1 exactly when in XFER and the counter equals 1.
REQ-012 A pop with counter=1 SHALL return the FSM to IDLE next cycle.
REQ-013 A new header arriving in the same cycle as the last pop SHALL be sampled in IDLE on the following cycle, giving no back-to-back ROUTE.
REQ-014 In XFER, ib_empty_i=1 or out_ready_i=0 SHALL stall the block: counter held, ib_read_o=0, state held.
REQ-015 nhr_write_o SHALL be 0 outside ROUTE.
REQ-016 nhr_address_o SHALL hold its value through XFER and return to 011 on entry to IDLE.
REQ-017 busy_o SHALL be 1 in ROUTE and XFER.
REQ-018 Counter arithmetic SHALL be LEN_WIDTH bits, and the counter SHALL never decrement below 1 while in XFER.

Reset
REQ-019 Asserting reset SHALL asynchronously force: state IDLE, counter 0, nhr_address_o=011, nhr_write_o=0, ib_read_o=0, pt_almost_done_o=0, busy_o=0.
REQ-020 Reset mid-packet SHALL abandon the packet; the remaining flits are not popped; after deassertion the flit at buffer head is treated as a header.

Configuration
REQ-021 With E_ROUTE_COMPUTE_STATS_EN defined, the block SHALL add output pkt_count_o [15:0], reset to 0, which increments by 1 on each final-flit pop and wraps from 0xFFFF to 0.
REQ-022 Without E_ROUTE_COMPUTE_STATS_EN, the pkt_count_o port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Scenario 1: LOCAL_X=1, LOCAL_Y=1, header dest(3,0) len=3, out_ready_i=1 -> nhr_write_o pulse with nhr_address_o=100; ib_read_o for 3 consecutive cycles; pt_almost_done_o on the 3rd; then IDLE with address 011.
REQ-024 Scenario 2: headers dest(1,2), (1,0), (1,1), (0,1), each with len=1 -> addresses 001, 010, 000, 101 respectively; each packet pops 1 flit.
REQ-025 Scenario 3: len=4 with out_ready_i=0 for 2 cycles after the 2nd pop -> counter holds at 2; ib_read_o=0; the remaining 2 flits pop after ready returns; 4 pops total.
REQ-026 Scenario 4: len=0 header -> treated as 1 flit; pt_almost_done_o=1 in the first XFER cycle.
REQ-027 Scenario 5: reset asserted mid-XFER of a len=5 packet after 2 pops -> outputs return to reset values immediately, without waiting for a clock edge.
REQ-028 Scenario 6 (E_ROUTE_COMPUTE_STATS_EN): 3 packets completed -> pkt_count_o=3; preload 0xFFFF and complete one packet -> pkt_count_o=0.
